// File: rtl/uart_sched_pkg.sv
// Shared types and IPU register-map constants for the UART TX scheduler.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        GUARD = 3'd3,
        POLL  = 3'd4
    } state_t;

    localparam logic        REG_CTRL  = 1'b0;
    localparam logic        REG_DATA  = 1'b1;
    localparam logic        ADDR_TX   = 1'b0;
    localparam logic        ADDR_RX   = 1'b1;
    localparam logic [31:0] CTRL_SEND = 32'h1;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous DEPTH x 8 byte FIFO with occupancy count and sticky overflow flag.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept then.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)      count <= count + CW'(1);
            else if (rd_en && !wr_en) count <= count - CW'(1);
            if (push && !wr_en) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Owns the IPU register port: drains the TX byte FIFO (load, send, poll) and arbitrates CPU pass-through.
// Optional POLL timeout with sticky err_o is enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [7:0]             push_data_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   ovf_o,
    output logic                   busy_o,
    input  logic                   cpu_req_i,
    input  logic                   cpu_we_i,
    input  logic                   cpu_reg_sel_i,
    input  logic                   cpu_addr_i,
    input  logic [31:0]            cpu_wdata_i,
    output logic                   cpu_gnt_o,
    output logic [31:0]            cpu_rdata_o,
    output logic                   ipu_wr_o,
    output logic                   ipu_reg_sel_o,
    output logic                   ipu_addr_o,
    output logic [31:0]            ipu_entrada_o,
    input  logic [31:0]            ipu_salida_i,
    output logic                   err_o
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_scheduler: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    state_t     state;
    state_t     state_nx;
    logic       prio;       // 0: CPU wins a tie, 1: engine wins
    logic       eng_req;
    logic       cpu_win;
    logic       eng_win;
    logic       pop;
    logic       timeout;
    logic [7:0] head;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_i),
        .push_data (push_data_i),
        .pop       (pop),
        .head      (head),
        .full      (full_o),
        .empty     (empty_o),
        .count     (count_o),
        .ovf       (ovf_o)
    );

    assign eng_req     = !empty_o;
    assign cpu_win     = cpu_req_i && (!eng_req || !prio);
    assign eng_win     = eng_req && (!cpu_req_i || prio);
    assign busy_o      = (state != IDLE);
    assign cpu_rdata_o = ipu_salida_i;

    always_comb begin
        state_nx      = state;
        ipu_wr_o      = 1'b0;
        ipu_reg_sel_o = REG_CTRL;
        ipu_addr_o    = ADDR_TX;
        ipu_entrada_o = '0;
        cpu_gnt_o     = 1'b0;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_win) begin
                    ipu_wr_o      = cpu_we_i;
                    ipu_reg_sel_o = cpu_reg_sel_i;
                    ipu_addr_o    = cpu_addr_i;
                    ipu_entrada_o = cpu_wdata_i;
                    cpu_gnt_o     = 1'b1;
                end else if (eng_win) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                ipu_wr_o      = 1'b1;
                ipu_reg_sel_o = REG_DATA;
                ipu_entrada_o = {24'h0, head};
                state_nx      = START;
            end
            START: begin
                ipu_wr_o      = 1'b1;
                ipu_entrada_o = CTRL_SEND;
                state_nx      = GUARD;
            end
            // One idle cycle lets the IPU raise its send-busy flag before the first poll.
            GUARD: state_nx = POLL;
            POLL: begin
                if (!ipu_salida_i[0] || timeout) begin
                    pop      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cpu_req_i && eng_req) prio <= ~prio;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] poll_cnt;

    assign timeout = (state == POLL) && ipu_salida_i[0] &&
                     (poll_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            poll_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            if (state != POLL) poll_cnt <= '0;
            else               poll_cnt <= poll_cnt + TW'(1);
            if (timeout) err_o <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural IPU (send-busy counter, fixed RX byte 0x5A).
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    logic        clk;
    logic        rst;
    logic        push_i;
    logic [7:0]  push_data_i;
    logic        full_o;
    logic        empty_o;
    logic [4:0]  count_o;
    logic        ovf_o;
    logic        busy_o;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic        cpu_reg_sel_i;
    logic        cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic        cpu_gnt_o;
    logic [31:0] cpu_rdata_o;
    logic        ipu_wr_o;
    logic        ipu_reg_sel_o;
    logic        ipu_addr_o;
    logic [31:0] ipu_entrada_o;
    logic [31:0] ipu_salida_i;
    logic        err_o;

    uart_tx_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .push_i(push_i), .push_data_i(push_data_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .ovf_o(ovf_o), .busy_o(busy_o),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_reg_sel_i(cpu_reg_sel_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o),
        .cpu_rdata_o(cpu_rdata_o), .ipu_wr_o(ipu_wr_o), .ipu_reg_sel_o(ipu_reg_sel_o),
        .ipu_addr_o(ipu_addr_o), .ipu_entrada_o(ipu_entrada_o), .ipu_salida_i(ipu_salida_i),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0]  tx_q [$];
    logic [32:0] cpu_q [$];   // {is_write, expected data}
    logic [32:0] mon_e;
    int busy_len = 20;
    int busy_cnt = 0;

    // IPU model: a CTRL write with bit0 starts a send that stays busy for busy_len cycles.
    always @(posedge clk) begin
        if (!rst) busy_cnt <= 0;
        else if (ipu_wr_o && ipu_reg_sel_o == REG_CTRL && ipu_entrada_o[0]) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign ipu_salida_i = (ipu_reg_sel_o == REG_CTRL) ? {31'b0, (busy_cnt != 0)} :
                          (ipu_addr_o == ADDR_RX) ? 32'h5A : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected no transaction", name, act);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (cpu_gnt_o) begin
                if (cpu_q.size() == 0) unexpected("cpu_grant", ipu_entrada_o);
                else begin
                    mon_e = cpu_q.pop_front();
                    if (mon_e[32]) begin
                        chk("cpu_wr_strobe", 32'(ipu_wr_o), 32'd1);
                        chk("cpu_wr_data", ipu_entrada_o, mon_e[31:0]);
                    end else begin
                        chk("cpu_rdata", cpu_rdata_o, mon_e[31:0]);
                    end
                end
            end else if (ipu_wr_o && ipu_reg_sel_o == REG_DATA && ipu_addr_o == ADDR_TX) begin
                if (tx_q.size() == 0) unexpected("tx_byte", ipu_entrada_o);
                else chk("tx_byte", ipu_entrada_o, {24'h0, tx_q.pop_front()});
            end else if (ipu_wr_o && ipu_reg_sel_o == REG_CTRL) begin
                chk("ctrl_send", ipu_entrada_o, CTRL_SEND);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        push_i = 1'b0;
        cpu_req_i = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ipu_wr", 32'(ipu_wr_o), 32'd0);
        chk("rst_cpu_gnt", 32'(cpu_gnt_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        tx_q.delete();
        cpu_q.delete();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(empty_o && !busy_o) && n < bound);
        chk(name, 32'(empty_o && !busy_o), 32'd1);
    endtask

    task automatic wait_load(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ipu_wr_o && ipu_reg_sel_o == REG_DATA) && n < 40);
        chk(name, 32'(ipu_wr_o && ipu_reg_sel_o == REG_DATA), 32'd1);
    endtask

    initial begin
        int bad;
        int n;
        rst = 1'b0; push_i = 1'b0; push_data_i = '0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_reg_sel_i = 1'b0; cpu_addr_i = 1'b0; cpu_wdata_i = '0;
        reset_dut();

        // Single byte; the FIFO must hold it until the IPU send flag drops.
        step(); push_i = 1'b1; push_data_i = 8'h48; tx_q.push_back(8'h48);
        step(); push_i = 1'b0;
        @(negedge clk);
        chk("t1_count", 32'(count_o), 32'd1);
        wait_load("t1_load_seen");
        bad = 0;
        repeat (19) begin
            @(negedge clk);
            if (empty_o) bad++;
        end
        chk("t1_held_while_busy", bad, 0);
        wait_idle(50, "t1_drain");
        chk("t1_busy", 32'(busy_o), 32'd0);

        // Overfill: 17th byte is dropped and sets ovf.
        for (int i = 0; i < 17; i++) begin
            step(); push_i = 1'b1; push_data_i = 8'h10 + 8'(i);
            if (i < 16) tx_q.push_back(8'h10 + 8'(i));
        end
        step(); push_i = 1'b0;
        @(negedge clk);
        chk("t2_full", 32'(full_o), 32'd1);
        chk("t2_count", 32'(count_o), 32'd16);
        chk("t2_ovf", 32'(ovf_o), 32'd1);
        wait_idle(1500, "t2_drain");
        chk("t2_ovf_sticky", 32'(ovf_o), 32'd1);
        chk("t2_txq", tx_q.size(), 0);

        // Full FIFO with push in the exact pop cycle.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            step(); push_i = 1'b1; push_data_i = 8'h30 + 8'(i); tx_q.push_back(8'h30 + 8'(i));
        end
        step(); push_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy_o && ipu_reg_sel_o == REG_CTRL && !ipu_wr_o && busy_cnt == 0) && n < 100);
        chk("t5_full_at_pop", 32'(count_o), 32'd16);
        push_i = 1'b1; push_data_i = 8'hC0; tx_q.push_back(8'hC0);
        step(); push_i = 1'b0;
        @(negedge clk);
        chk("t5_count", 32'(count_o), 32'd16);
        chk("t5_ovf", 32'(ovf_o), 32'd0);
        wait_idle(1500, "t5_drain");
        chk("t5_txq", tx_q.size(), 0);

        // Arbitration: CPU wins first tie, engine wins the next.
        reset_dut();
        step(); push_i = 1'b1; push_data_i = 8'hA1; tx_q.push_back(8'hA1);
        step(); push_i = 1'b0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_reg_sel_i = REG_DATA; cpu_addr_i = ADDR_RX;
        cpu_q.push_back({1'b0, 32'h5A});
        @(negedge clk);
        chk("t3_cpu_first", 32'(cpu_gnt_o), 32'd1);
        chk("t3_engine_waits", 32'(busy_o), 32'd0);
        step(); cpu_req_i = 1'b0;
        wait_idle(100, "t3_drain1");
        step(); push_i = 1'b1; push_data_i = 8'hB2; tx_q.push_back(8'hB2);
        step(); push_i = 1'b0; cpu_req_i = 1'b1;
        cpu_q.push_back({1'b0, 32'h5A});
        @(negedge clk);
        chk("t3_engine_wins", 32'(cpu_gnt_o), 32'd0);
        step();
        @(negedge clk);
        chk("t3_engine_load", 32'(busy_o), 32'd1);
        // CPU keeps requesting through the whole byte.
        bad = 0; n = 0;
        while (busy_o && n < 100) begin
            if (cpu_gnt_o) bad++;
            @(negedge clk);
            n++;
        end
        chk("t4_no_gnt_while_busy", bad, 0);
        chk("t4_gnt_in_idle", 32'(cpu_gnt_o), 32'd1);
        step(); cpu_req_i = 1'b0;
        step();
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_reg_sel_i = REG_CTRL; cpu_addr_i = ADDR_TX;
        cpu_wdata_i = 32'h10; cpu_q.push_back({1'b1, 32'h10});
        @(negedge clk);
        chk("t4_cpu_write_gnt", 32'(cpu_gnt_o), 32'd1);
        step(); cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        chk("t4_cpuq", cpu_q.size(), 0);

`ifdef UART_TX_TIMEOUT_EN
        reset_dut();
        busy_len = 100000;
        step(); push_i = 1'b1; push_data_i = 8'h77; tx_q.push_back(8'h77);
        step(); push_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_o && n < 200);
        chk("t6_err", 32'(err_o), 32'd1);
        wait_idle(20, "t6_popped");
        busy_len = 20;
`endif

        // Reset in the middle of LOAD.
        step(); push_i = 1'b1; push_data_i = 8'h66; tx_q.push_back(8'h66);
        step(); push_i = 1'b0;
        wait_load("t6_load_seen");
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_empty", 32'(empty_o), 32'd1);
        chk("t6_rst_err", 32'(err_o), 32'd0);
        step(); rst = 1'b1;

        chk("queues_empty", tx_q.size() + cpu_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the summary line");
        $fatal(1);
    end

endmodule
